force_sequencer: RTL and testbench

Per-frame scheduler for the force stage of the soft-body update. On each step request it launches the force generators (torque, spring, gravity, ...) one at a time over their `begin_in`/`result_out` handshake and sums the per-node force streams into signed saturating accumulators. When every source has finished, it publishes the frame's net force per node to the integrator. This serialises the force units onto one accumulator bank so no adder tree is needed per source.

---
 rtl/force_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_force_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_sequencer.sv
// force_sequencer: per-frame scheduler for the soft-body force stage.
// On a step request it launches each force source in index order, sums the
// per-node force stream of the active source into one bank of signed
// saturating accumulators, then publishes the frame's net force per node.
//
// Ports:
//   clk_in         single clock
//   rst_in         synchronous active-high reset
//   step_in        frame-start pulse, honoured only when idle
//   src_begin_out  one-hot, one-cycle launch pulse per source
//   src_valid_in   force-valid per source
//   src_fx_in      signed x force component per source
//   src_fy_in      signed y force component per source
//   src_done_in    completion pulse per source
//   net_fx_out     published net x force per node
//   net_fy_out     published net y force per node
//   step_done_out  one-cycle pulse when net_* is updated
//   busy_out       frame in progress
//   err_out        sticky errors: bit0 timeout, bit1 short/long stream
module force_sequencer #(
  parameter int unsigned NUM_NODES   = 10,
  parameter int unsigned NUM_SOURCES = 3,
  parameter int unsigned FORCE_SIZE  = 8,
  parameter int unsigned ACC_SIZE    = 12,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    step_in,
  output logic [NUM_SOURCES-1:0]                  src_begin_out,
  input  logic [NUM_SOURCES-1:0]                  src_valid_in,
  input  logic [NUM_SOURCES-1:0][FORCE_SIZE-1:0]  src_fx_in,
  input  logic [NUM_SOURCES-1:0][FORCE_SIZE-1:0]  src_fy_in,
  input  logic [NUM_SOURCES-1:0]                  src_done_in,
  output logic [NUM_NODES-1:0][ACC_SIZE-1:0]      net_fx_out,
  output logic [NUM_NODES-1:0][ACC_SIZE-1:0]      net_fy_out,
  output logic                                    step_done_out,
  output logic                                    busy_out,
  output logic [1:0]                              err_out
);

  localparam int unsigned K_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int unsigned N_W = $clog2(NUM_NODES + 1);
  localparam int unsigned T_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_COLLECT,
    S_NEXT,
    S_PUBLISH
  } state_t;

  state_t                               state;
  logic [K_W-1:0]                       src_idx;
  logic [N_W-1:0]                       node_idx;
  logic [T_W-1:0]                       wait_cnt;
  logic [NUM_NODES-1:0][ACC_SIZE-1:0]   acc_x;
  logic [NUM_NODES-1:0][ACC_SIZE-1:0]   acc_y;

  logic                  cur_valid;
  logic                  cur_done;
  logic [FORCE_SIZE-1:0] cur_fx;
  logic [FORCE_SIZE-1:0] cur_fy;
  logic                  take_c;
  logic [N_W-1:0]        node_after;

  // Signed add at ACC_SIZE+1 bits, clamped to the accumulator range.
  function automatic logic [ACC_SIZE-1:0] sat_add(input logic [ACC_SIZE-1:0]   acc,
                                                  input logic [FORCE_SIZE-1:0] f);
    logic [ACC_SIZE:0] sum;
    sum = {acc[ACC_SIZE-1], acc} +
          {{(ACC_SIZE + 1 - FORCE_SIZE){f[FORCE_SIZE-1]}}, f};
    if (sum[ACC_SIZE] != sum[ACC_SIZE-1]) begin
      return sum[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                           : {1'b0, {(ACC_SIZE-1){1'b1}}};
    end
    return sum[ACC_SIZE-1:0];
  endfunction

  // Only the launched source is observed; the others are ignored.
  always_comb begin
    cur_valid  = src_valid_in[src_idx];
    cur_done   = src_done_in[src_idx];
    cur_fx     = src_fx_in[src_idx];
    cur_fy     = src_fy_in[src_idx];
    take_c     = cur_valid && (node_idx < N_W'(NUM_NODES));
    // Node count as seen by a same-cycle done (valid is applied first).
    node_after = node_idx + N_W'(take_c);
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      src_idx       <= '0;
      node_idx      <= '0;
      wait_cnt      <= '0;
      acc_x         <= '0;
      acc_y         <= '0;
      src_begin_out <= '0;
      net_fx_out    <= '0;
      net_fy_out    <= '0;
      step_done_out <= 1'b0;
      busy_out      <= 1'b0;
      err_out       <= '0;
    end else begin
      src_begin_out <= '0;
      step_done_out <= 1'b0;

      case (state)
        S_IDLE: begin
          busy_out <= 1'b0;
          // Blocked during the publish pulse so a new frame starts one cycle later.
          if (step_in && !step_done_out) begin
            err_out  <= '0;
            src_idx  <= '0;
            busy_out <= 1'b1;
            state    <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          acc_x         <= '0;
          acc_y         <= '0;
          src_begin_out <= NUM_SOURCES'(1) << src_idx;
          state         <= S_LAUNCH;
        end

        S_LAUNCH: begin
          node_idx <= '0;
          wait_cnt <= '0;
          state    <= S_COLLECT;
        end

        S_COLLECT: begin
          if (take_c) begin
            acc_x[node_idx] <= sat_add(acc_x[node_idx], cur_fx);
            acc_y[node_idx] <= sat_add(acc_y[node_idx], cur_fy);
            node_idx        <= node_after;
          end else if (cur_valid) begin
            err_out[1] <= 1'b1;
          end

          if (cur_done) begin
            if (node_after != N_W'(NUM_NODES)) begin
              err_out[1] <= 1'b1;
            end
            state <= S_NEXT;
          end else if (wait_cnt == T_W'(TIMEOUT - 1)) begin
            // Abandon the source; partial sums stay in the bank.
            err_out[0] <= 1'b1;
            state      <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + T_W'(1);
          end
        end

        S_NEXT: begin
          if (src_idx == K_W'(NUM_SOURCES - 1)) begin
            state <= S_PUBLISH;
          end else begin
            src_idx       <= src_idx + K_W'(1);
            src_begin_out <= NUM_SOURCES'(1) << (src_idx + K_W'(1));
            state         <= S_LAUNCH;
          end
        end

        S_PUBLISH: begin
          net_fx_out    <= acc_x;
          net_fy_out    <= acc_y;
          step_done_out <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_force_sequencer.sv
// Directed bench for force_sequencer: a default instance and an 8-bit
// accumulator instance share all source inputs; expected frame results are
// queued when a frame is driven and compared when step_done_out pulses.
module tb_force_sequencer;

  localparam int NN  = 10;
  localparam int NS  = 3;
  localparam int FS  = 8;
  localparam int AS  = 12;
  localparam int AS8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   step;
  logic [NS-1:0]          valid;
  logic [NS-1:0]          done;
  logic [NS-1:0][FS-1:0]  fx;
  logic [NS-1:0][FS-1:0]  fy;

  logic [NS-1:0]          beg_a, beg_b;
  logic [NN-1:0][AS-1:0]  nfx_a, nfy_a;
  logic [NN-1:0][AS8-1:0] nfx_b, nfy_b;
  logic                   sd_a, sd_b, busy_a, busy_b;
  logic [1:0]             err_a, err_b;

  force_sequencer dut_a (
    .clk_in(clk), .rst_in(rst), .step_in(step),
    .src_begin_out(beg_a), .src_valid_in(valid),
    .src_fx_in(fx), .src_fy_in(fy), .src_done_in(done),
    .net_fx_out(nfx_a), .net_fy_out(nfy_a),
    .step_done_out(sd_a), .busy_out(busy_a), .err_out(err_a)
  );

  force_sequencer #(.ACC_SIZE(AS8)) dut_b (
    .clk_in(clk), .rst_in(rst), .step_in(step),
    .src_begin_out(beg_b), .src_valid_in(valid),
    .src_fx_in(fx), .src_fy_in(fy), .src_done_in(done),
    .net_fx_out(nfx_b), .net_fy_out(nfy_b),
    .step_done_out(sd_b), .busy_out(busy_b), .err_out(err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  int cfg_nv[NS];
  bit cfg_dn[NS];
  int cfg_fx[NS];
  int cfg_fy[NS];
  bit cfg_noise;

  typedef struct {
    int fx[NN];
    int fy[NN];
    int fx8[NN];
    int fy8[NN];
    int err;
    int lat;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic wait_begin(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (beg_a[k]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("begin%0d_seen", k), int'(ok), 1);
  endtask

  task automatic set_cfg(input int nv0, input int nv1, input int nv2,
                         input bit dn0, input bit dn1, input bit dn2,
                         input int f_x, input int f_y, input bit noise);
    cfg_nv[0] = nv0; cfg_nv[1] = nv1; cfg_nv[2] = nv2;
    cfg_dn[0] = dn0; cfg_dn[1] = dn1; cfg_dn[2] = dn2;
    for (int k = 0; k < NS; k++) begin
      cfg_fx[k] = f_x;
      cfg_fy[k] = f_y;
    end
    cfg_noise = noise;
  endtask

  task automatic drive_frame(input string name, input int exp_lat);
    exp_t e;
    exp_t got;
    int   t0;
    bit   seen;

    // Reference model: per-add saturation at both accumulator widths.
    e.err = 0;
    e.lat = exp_lat;
    for (int n = 0; n < NN; n++) begin
      e.fx[n] = 0; e.fy[n] = 0; e.fx8[n] = 0; e.fy8[n] = 0;
    end
    for (int k = 0; k < NS; k++) begin
      for (int i = 0; i < cfg_nv[k]; i++) begin
        if (i < NN) begin
          e.fx[i]  = sat(e.fx[i]  + cfg_fx[k], AS);
          e.fy[i]  = sat(e.fy[i]  + cfg_fy[k], AS);
          e.fx8[i] = sat(e.fx8[i] + cfg_fx[k], AS8);
          e.fy8[i] = sat(e.fy8[i] + cfg_fy[k], AS8);
        end else begin
          e.err = e.err | 2;
        end
      end
      if (cfg_dn[k] && cfg_nv[k] != NN) e.err = e.err | 2;
      if (!cfg_dn[k]) e.err = e.err | 1;
    end
    sb.push_back(e);

    t0   = cyc;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk({name, "_busy_rise"}, int'(busy_a), 1);

    for (int k = 0; k < NS; k++) begin
      wait_begin(k);
      tick();
      for (int i = 0; i < cfg_nv[k]; i++) begin
        valid    = '0;
        valid[k] = 1'b1;
        fx[k]    = (i < NN) ? FS'(cfg_fx[k]) : FS'(100);
        fy[k]    = FS'(cfg_fy[k]);
        if (k == 0 && cfg_noise && i == 3) begin
          step     = 1'b1;
          valid[2] = 1'b1;
          fx[2]    = FS'(55);
          fy[2]    = FS'(55);
          chk({name, "_noise_begin"}, int'(beg_a), 0);
          chk({name, "_noise_busy"}, int'(busy_a), 1);
        end
        tick();
        step  = 1'b0;
        valid = '0;
        fx    = '0;
        fy    = '0;
      end
      if (cfg_dn[k]) begin
        done[k] = 1'b1;
        tick();
        done = '0;
      end
    end

    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sd_a) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_done_seen"}, int'(seen), 1);

    if (seen && sb.size() > 0) begin
      got = sb.pop_front();
      if (got.lat >= 0) chk({name, "_latency"}, cyc - t0, got.lat);
      for (int n = 0; n < NN; n++) begin
        chk($sformatf("%s_fx%0d", name, n), int'($signed(nfx_a[n])), got.fx[n]);
        chk($sformatf("%s_fy%0d", name, n), int'($signed(nfy_a[n])), got.fy[n]);
        chk($sformatf("%s_fx8_%0d", name, n), int'($signed(nfx_b[n])), got.fx8[n]);
        chk($sformatf("%s_fy8_%0d", name, n), int'($signed(nfy_b[n])), got.fy8[n]);
      end
      chk({name, "_err"}, int'(err_a), got.err);
      chk({name, "_err8"}, int'(err_b), got.err);
      chk({name, "_busy_at_done"}, int'(busy_a), 1);
      tick();
      chk({name, "_done_pulse"}, int'(sd_a), 0);
      chk({name, "_busy_fall"}, int'(busy_a), 0);
    end
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    step  = 1'b0;
    valid = '0;
    done  = '0;
    fx    = '0;
    fy    = '0;
    cfg_noise = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", int'(busy_a), 0);
    chk("rst_begin", int'(beg_a), 0);
    chk("rst_step_done", int'(sd_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_net_fx0", int'(nfx_a[0]), 0);
    chk("rst_net_fy9", int'(nfy_a[9]), 0);
    tick();

    set_cfg(10, 10, 10, 1, 1, 1, 1, -2, 0);
    drive_frame("basic", 42);

    set_cfg(10, 10, 10, 1, 1, 1, 127, -128, 0);
    drive_frame("sat", 42);

    set_cfg(10, 10, 10, 1, 0, 1, 5, -1, 0);
    drive_frame("timeout", -1);

    set_cfg(9, 10, 10, 1, 1, 1, 2, 3, 0);
    drive_frame("short", -1);

    set_cfg(11, 10, 10, 1, 1, 1, 2, 3, 0);
    drive_frame("long", -1);

    set_cfg(10, 10, 10, 1, 1, 1, 7, -4, 1);
    drive_frame("noise", 42);

    // Reset while source 1 is streaming: nothing may be published.
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_begin(1);
    tick();
    for (int i = 0; i < 2; i++) begin
      valid[1] = 1'b1;
      fx[1]    = FS'(9);
      fy[1]    = FS'(9);
      tick();
    end
    valid = '0;
    fx    = '0;
    fy    = '0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_net_fx0", int'(nfx_a[0]), 0);
    chk("midrst_net_fy0", int'(nfy_a[0]), 0);
    chk("midrst_err", int'(err_a), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midrst_no_done%0d", i), int'(sd_a), 0);
      tick();
    end

    set_cfg(10, 10, 10, 1, 1, 1, -3, 4, 0);
    drive_frame("after_rst", 42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
